// File: rtl/ahb_slave_mux_if.sv
// AHB slave-side mux bundle.
// Carries the manager address phase (HADDR/HTRANS) and the decoded selects
// (HSEL). It also carries the per-slave return paths (HRDATAS/HREADYOUTS/HRESPS),
// the muxed data phase back to the manager (HRDATA/HREADY/HRESP) and the
// sticky timeout flag with its clear (TimeoutErr/TimeoutClr).
// Modport slave: the mux side. Modport master: the manager/slaves environment.
interface ahb_slave_mux_if #(
  parameter int unsigned NSLV = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 64
);
  logic [AW-1:0]            HADDR;
  logic [1:0]               HTRANS;
  logic [NSLV-1:0]          HSEL;
  logic [NSLV-1:0][DW-1:0]  HRDATAS;
  logic [NSLV-1:0]          HREADYOUTS;
  logic [NSLV-1:0]          HRESPS;
  logic [DW-1:0]            HRDATA;
  logic                     HREADY;
  logic                     HRESP;
  logic                     TimeoutErr;
  logic                     TimeoutClr;

  modport slave (
    input  HADDR, HTRANS, HRDATAS, HREADYOUTS, HRESPS, TimeoutClr,
    output HSEL, HRDATA, HREADY, HRESP, TimeoutErr
  );

  modport master (
    output HADDR, HTRANS, HRDATAS, HREADYOUTS, HRESPS, TimeoutClr,
    input  HSEL, HRDATA, HREADY, HRESP, TimeoutErr
  );
endinterface

// File: rtl/ahb_slave_mux.sv
// AHB address decoder and slave-to-manager response mux.
// Decodes HADDR into one-hot HSEL (lowest index wins on overlap) and tracks
// the data-phase owner. Read data, ready and response are muxed back from
// that owner. Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR response,
// and an optional wait-state timeout turns a hung slave into an ERROR.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus           : ahb_slave_mux_if.slave (address phase in, HSEL out,
//                   slave returns in, muxed HRDATA/HREADY/HRESP out,
//                   TimeoutErr out, TimeoutClr in)
module ahb_slave_mux #(
  parameter int unsigned NSLV = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 64,
  parameter logic [AW-1:0] BASE  [NSLV] = '{32'h1000_0000, 32'h0200_0000,
                                            32'h0C00_0000, 32'h8000_0000},
  parameter logic [AW-1:0] RANGE [NSLV] = '{32'h0000_0007, 32'h0000_FFFF,
                                            32'h03FF_FFFF, 32'h7FFF_FFFF},
  parameter int unsigned TIMEOUT = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_slave_mux_if.slave     bus
);

  localparam int unsigned    CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TLIM     = CW'(TIMEOUT);
  localparam logic [NSLV:0]  NONE_SEL = {1'b1, {NSLV{1'b0}}};

  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

  state_t          state;
  logic [NSLV:0]   dsel;       // [NSLV] is the "none" bit
  logic [CW-1:0]   cnt;
  logic            terr;

  logic [NSLV-1:0] hsel_c;
  logic            hit_c;
  logic            hready_c;
  logic            hresp_c;
  logic [DW-1:0]   hrdata_c;
  logic            waiting_c;
  logic            tout_c;
  logic            err_req_c;
  logic [CW-1:0]   cnt_inc_c;

  // Address decode; scan high to low so the lowest matching index wins.
  always_comb begin
    hsel_c = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if (({1'b0, bus.HADDR} >= {1'b0, BASE[i]}) &&
          ({1'b0, bus.HADDR} <= ({1'b0, BASE[i]} + {1'b0, RANGE[i]}))) begin
        hsel_c    = '0;
        hsel_c[i] = 1'b1;
      end
    end
  end

  assign hit_c = |hsel_c;

  // Data-phase response mux; error states override the owning slave.
  always_comb begin
    hready_c = 1'b1;
    hresp_c  = 1'b0;
    hrdata_c = '0;
    case (state)
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = 1'b1;
      end
      ST_ERR2: begin
        hresp_c  = 1'b1;
      end
      default: begin
        for (int i = 0; i < int'(NSLV); i++) begin
          if (dsel[i]) begin
            hready_c = bus.HREADYOUTS[i];
            hresp_c  = bus.HRESPS[i];
            hrdata_c = bus.HRDATAS[i];
          end
        end
      end
    endcase
  end

  // Wait-state tracking: only a selected slave stalling in OK counts.
  assign waiting_c = (state == ST_OK) && !dsel[NSLV] && !hready_c;
  assign cnt_inc_c = (cnt == TLIM) ? cnt : cnt + CW'(1);
  assign tout_c    = (TIMEOUT != 0) && waiting_c && (cnt_inc_c == TLIM);
  assign err_req_c = hready_c && bus.HTRANS[1] && !hit_c;

  // State, data-phase owner, timeout counter and sticky flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_OK;
      dsel  <= NONE_SEL;
      cnt   <= '0;
      terr  <= 1'b0;
    end else begin
      cnt <= (waiting_c && (TIMEOUT != 0)) ? cnt_inc_c : '0;

      // A new timeout beats a simultaneous clear.
      if (tout_c) begin
        terr <= 1'b1;
      end else if (bus.TimeoutClr) begin
        terr <= 1'b0;
      end

      case (state)
        ST_ERR1: begin
          // Drop any hung owner so its outputs are ignored from ERR2 onward.
          state <= ST_ERR2;
          dsel  <= NONE_SEL;
        end
        default: begin
          if (tout_c) begin
            state <= ST_ERR1;
          end else if (hready_c) begin
            dsel  <= {~hit_c, hsel_c};
            state <= err_req_c ? ST_ERR1 : ST_OK;
          end
        end
      endcase
    end
  end

  assign bus.HSEL       = hsel_c;
  assign bus.HREADY     = hready_c;
  assign bus.HRESP      = hresp_c;
  assign bus.HRDATA     = hrdata_c;
  assign bus.TimeoutErr = terr;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed bench for ahb_slave_mux (default map, TIMEOUT=8).
// A transaction-level model tracks who owns the data phase and which error
// beat is due. A negedge compare process checks every output against that
// model, and literal checks pin the model to hand-computed values.
module tb_ahb_slave_mux;
  localparam int unsigned TMO = 8;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic HCLK = 1'b0;
  logic HRESETn;

  ahb_slave_mux_if #(.NSLV(4), .AW(32), .DW(64)) bus ();

  ahb_slave_mux #(.TIMEOUT(TMO)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_err = 0;

  // Address map as plain numbers.
  longint unsigned mbase  [4] = '{64'h1000_0000, 64'h0200_0000, 64'h0C00_0000, 64'h8000_0000};
  longint unsigned mrange [4] = '{64'h7, 64'hFFFF, 64'h03FF_FFFF, 64'h7FFF_FFFF};

  // Model state: data-phase owner (-1 = nobody), error beat due (0/1/2),
  // consecutive wait cycles and the sticky timeout flag.
  int m_owner = -1;
  int m_phase = 0;
  int m_wait  = 0;
  bit m_terr  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (64'(a) >= mbase[i] && 64'(a) <= mbase[i] + mrange[i]) return i;
    return -1;
  endfunction

  function automatic void expect_out(output logic r, output logic s, output logic [63:0] d);
    r = 1'b1; s = 1'b0; d = '0;
    if (m_phase == 1) begin
      r = 1'b0; s = 1'b1;
    end else if (m_phase == 2) begin
      s = 1'b1;
    end else if (m_owner >= 0) begin
      r = bus.HREADYOUTS[m_owner];
      s = bus.HRESPS[m_owner];
      d = bus.HRDATAS[m_owner];
    end
  endfunction

  task automatic model_reset();
    m_owner = -1; m_phase = 0; m_wait = 0; m_terr = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_step();
    logic r, s;
    logic [63:0] d;
    int idx;
    bit set;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    expect_out(r, s, d);
    set = 1'b0;
    if (m_phase == 1) begin
      m_phase = 2; m_owner = -1; m_wait = 0;
    end else if (r) begin
      idx     = decode(bus.HADDR);
      m_owner = idx;
      m_phase = (bus.HTRANS[1] && idx < 0) ? 1 : 0;
      m_wait  = 0;
    end else begin
      m_wait++;
      if (m_wait == TMO) begin
        m_phase = 1; m_wait = 0; m_terr = 1'b1; set = 1'b1;
      end
    end
    if (bus.TimeoutClr && !set) m_terr = 1'b0;
  endtask

  // Every-cycle comparison against the model.
  logic        c_r, c_s;
  logic [63:0] c_d;
  int          c_idx;
  always @(negedge HCLK) begin
    expect_out(c_r, c_s, c_d);
    c_idx = decode(bus.HADDR);
    chk("hsel",   64'(bus.HSEL), (c_idx < 0) ? 64'd0 : (64'd1 << c_idx));
    chk("hready", 64'(bus.HREADY), 64'(c_r));
    chk("hresp",  64'(bus.HRESP),  64'(c_s));
    chk("hrdata", bus.HRDATA, c_d);
    chk("terr",   64'(bus.TimeoutErr), 64'(m_terr));
  end

  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    bus.HADDR  = a;
    bus.HTRANS = t;
  endtask

  task automatic chk_rr(input string name, input logic r, input logic s);
    chk({name, "_hready"}, 64'(bus.HREADY), 64'(r));
    chk({name, "_hresp"},  64'(bus.HRESP),  64'(s));
  endtask

  logic [31:0] b_addr [8] = '{32'h1000_0007, 32'h1000_0008, 32'h0FFF_FFFF, 32'h0BFF_FFFF,
                              32'h0200_FFFF, 32'h0201_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic [3:0]  b_sel  [8] = '{4'b0001, 4'b0000, 4'b0100, 4'b0000,
                              4'b0010, 4'b0000, 4'b1000, 4'b0000};
  logic [1:0]  rr_seq [4] = '{2'b01, 2'b11, 2'b01, 2'b11};

  initial begin
    HRESETn        = 1'b0;
    drive(32'h8000_0010, IDLE);
    bus.HREADYOUTS = '1;
    bus.HRESPS     = '0;
    for (int i = 0; i < 4; i++) bus.HRDATAS[i] = 64'h1111 * 64'(i + 1);
    bus.TimeoutClr = 1'b0;

    // Reset state; HSEL still decodes while in reset.
    repeat (2) tick();
    #1;
    chk("rst_hsel", 64'(bus.HSEL), 64'h8);
    chk_rr("rst", 1'b1, 1'b0);
    chk("rst_hrdata", bus.HRDATA, 64'h0);
    chk("rst_terr", 64'(bus.TimeoutErr), 64'h0);
    HRESETn = 1'b1;
    drive(32'h0, IDLE);
    tick();
    #1;
    chk_rr("post_rst", 1'b1, 1'b0);
    chk("post_rst_hrdata", bus.HRDATA, 64'h0);

    // Slave 3 read with two wait states.
    drive(32'h8000_0010, NONSEQ);
    bus.HRDATAS[3] = 64'hDEAD;
    #1 chk("s3_hsel", 64'(bus.HSEL), 64'h8);
    tick();
    drive(32'h0, IDLE);
    bus.HREADYOUTS[3] = 1'b0;
    #1 chk_rr("s3_wait1", 1'b0, 1'b0);
    tick();
    #1 chk_rr("s3_wait2", 1'b0, 1'b0);
    tick();
    bus.HREADYOUTS[3] = 1'b1;
    #1 chk_rr("s3_done", 1'b1, 1'b0);
    chk("s3_data", bus.HRDATA, 64'hDEAD);
    tick();

    // Back-to-back unmapped NONSEQ: ERR1/ERR2 alternate.
    drive(32'h0000_1000, NONSEQ);
    #1 chk("unm_hsel", 64'(bus.HSEL), 64'h0);
    chk_rr("unm_addr", 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) drive(32'h0000_1000, IDLE);
      #1 chk_rr("unm_seq", rr_seq[k][1], rr_seq[k][0]);
    end
    tick();
    #1 chk_rr("unm_idle_exit", 1'b1, 1'b0);
    tick();
    #1 chk_rr("unm_idle_okay", 1'b1, 1'b0);

    // Slave error passes straight through, no extra cycles.
    drive(32'h0200_0004, NONSEQ);
    tick();
    drive(32'h0, IDLE);
    bus.HREADYOUTS[1] = 1'b0;
    bus.HRESPS[1]     = 1'b1;
    #1 chk_rr("s1_err1", 1'b0, 1'b1);
    tick();
    bus.HREADYOUTS[1] = 1'b1;
    #1 chk_rr("s1_err2", 1'b1, 1'b1);
    tick();
    bus.HRESPS[1] = 1'b0;
    #1 chk_rr("s1_after", 1'b1, 1'b0);

    // Decode boundaries.
    for (int k = 0; k < 8; k++) begin
      drive(b_addr[k], IDLE);
      #1 chk("bound_hsel", 64'(bus.HSEL), 64'(b_sel[k]));
      tick();
    end

    // Timeout on a stuck slave 0; clear held high until the set edge.
    drive(32'h1000_0000, NONSEQ);
    tick();
    drive(32'h0, IDLE);
    bus.HREADYOUTS[0] = 1'b0;
    bus.TimeoutClr    = 1'b1;
    for (int c = 0; c < int'(TMO); c++) begin
      #1 chk_rr("tmo_wait", 1'b0, 1'b0);
      tick();
    end
    bus.TimeoutClr = 1'b0;
    #1 chk_rr("tmo_err1", 1'b0, 1'b1);
    chk("tmo_set_wins", 64'(bus.TimeoutErr), 64'h1);
    tick();
    #1 chk_rr("tmo_err2", 1'b1, 1'b1);
    tick();
    #1 chk_rr("tmo_ignored", 1'b1, 1'b0);
    chk("tmo_sticky", 64'(bus.TimeoutErr), 64'h1);
    bus.TimeoutClr = 1'b1;
    tick();
    bus.TimeoutClr = 1'b0;
    #1 chk("tmo_cleared", 64'(bus.TimeoutErr), 64'h0);
    bus.HREADYOUTS[0] = 1'b1;
    tick();

    // Reset asserted in ERR1 takes effect without a clock edge.
    drive(32'h0000_1000, NONSEQ);
    tick();
    drive(32'h0, IDLE);
    #1 chk_rr("pre_rst_err1", 1'b0, 1'b1);
    HRESETn = 1'b0;
    model_reset();
    #1 chk_rr("async_rst", 1'b1, 1'b0);
    tick();
    HRESETn = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
